// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped responder beside dmem on the core's data bus.
// It decodes a 32-byte window and holds a free-running timer, a compare/match
// flag with interrupt, and a byte output FIFO drained over a valid/ready port.
// Reads are combinational; writes land on the rising clock edge.
// Optional build macro MMIO_PRESCALE_EN adds a PRESCALE register at offset 0x14
// that slows the timer down.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Architectural state
  logic [31:0]   timer_r;
  logic [31:0]   cmp_r;
  logic          timer_en_r;
  logic          irq_en_r;
  logic          match_r;
  logic          ovf_r;
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
`ifdef MMIO_PRESCALE_EN
  logic [31:0]   prescale_r;
  logic [31:0]   pscnt_r;
`endif

  // Decode and handshake terms
  logic [2:0] offset_s;
  logic       wr_s;
  logic       wr_timer_s;
  logic       wr_cmp_s;
  logic       wr_status_s;
  logic       wr_tx_s;
  logic       wr_ctrl_s;
  logic       full_s;
  logic       empty_s;
  logic       pop_s;
  logic       push_s;
  logic       tick_s;
  logic       unused_addr_bits;

  // The byte lane within a word is irrelevant: registers are whole words.
  assign unused_addr_bits = ^a[1:0];

  assign hit         = (a[31:5] == BASE_ADDR[31:5]);
  assign offset_s    = a[4:2];
  assign wr_s        = we & hit;
  assign wr_timer_s  = wr_s && (offset_s == 3'd0);
  assign wr_cmp_s    = wr_s && (offset_s == 3'd1);
  assign wr_status_s = wr_s && (offset_s == 3'd2);
  assign wr_tx_s     = wr_s && (offset_s == 3'd3);
  assign wr_ctrl_s   = wr_s && (offset_s == 3'd4);

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  // A pop frees a slot in the same edge, so a push into a full FIFO that
  // coincides with a pop is accepted.
  assign pop_s  = !empty_s && out_ready;
  assign push_s = wr_tx_s && (!full_s || pop_s);

`ifdef MMIO_PRESCALE_EN
  logic wr_prescale_s;
  assign wr_prescale_s = wr_s && (offset_s == 3'd5);
  assign tick_s        = timer_en_r && (pscnt_r == prescale_r);
`else
  assign tick_s = timer_en_r;
`endif

  assign out_valid = !empty_s;
  assign out_data  = empty_s ? 8'h00 : mem_r[rptr_r];
  assign irq       = match_r & irq_en_r;

  // Combinational register read mux; misses return zero.
  always_comb begin
    rd = 32'h0000_0000;
    if (hit) begin
      case (offset_s)
        3'd0:    rd = timer_r;
        3'd1:    rd = cmp_r;
        3'd2:    rd = {28'h000_0000, ovf_r, empty_s, full_s, match_r};
        3'd3:    rd = {{(32-CW){1'b0}}, count_r};
        3'd4:    rd = {30'h0000_0000, irq_en_r, timer_en_r};
`ifdef MMIO_PRESCALE_EN
        3'd5:    rd = prescale_r;
`endif
        default: rd = 32'h0000_0000;
      endcase
    end else begin
      rd = 32'h0000_0000;
    end
  end

  // Timer: a bus write takes priority over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 32'h0000_0000;
    end else if (wr_timer_s) begin
      timer_r <= wd;
    end else if (tick_s) begin
      timer_r <= timer_r + 32'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

`ifdef MMIO_PRESCALE_EN
  // Prescaler: counts enabled cycles up to PRESCALE, restarting on any write
  // to PRESCALE or TIMER so the next increment is a full period away.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_r <= 32'h0000_0000;
      pscnt_r    <= 32'h0000_0000;
    end else begin
      if (wr_prescale_s) begin
        prescale_r <= wd;
      end else begin
        prescale_r <= prescale_r;
      end
      if (wr_prescale_s || wr_timer_s) begin
        pscnt_r <= 32'h0000_0000;
      end else if (tick_s) begin
        pscnt_r <= 32'h0000_0000;
      end else if (timer_en_r) begin
        pscnt_r <= pscnt_r + 32'd1;
      end else begin
        pscnt_r <= pscnt_r;
      end
    end
  end
`endif

  // Compare and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_r      <= 32'hFFFF_FFFF;
      timer_en_r <= 1'b0;
      irq_en_r   <= 1'b0;
    end else begin
      if (wr_cmp_s) begin
        cmp_r <= wd;
      end else begin
        cmp_r <= cmp_r;
      end
      if (wr_ctrl_s) begin
        timer_en_r <= wd[0];
        irq_en_r   <= wd[1];
      end else begin
        timer_en_r <= timer_en_r;
        irq_en_r   <= irq_en_r;
      end
    end
  end

  // Sticky status flags: a match set beats a same-cycle clear; overflow is
  // raised whenever a TX byte has to be dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (tick_s && (timer_r == cmp_r)) begin
        match_r <= 1'b1;
      end else if (wr_status_s && wd[0]) begin
        match_r <= 1'b0;
      end else begin
        match_r <= match_r;
      end
      if (wr_tx_s && !push_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s && wd[3]) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Circular byte FIFO; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= wd[7:0];
        wptr_r        <= wptr_r + AW'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end else begin
        rptr_r <= rptr_r;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model of the register map.
module tb_mmio_responder;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] wd = 32'h0;
  logic        out_ready = 1'b0;
  logic [31:0] rd;
  logic        hit;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        irq;

  int errors = 0;
  int checks = 0;

  mmio_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .hit(hit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_timer, m_cmp;
  logic        m_ten, m_ien, m_match, m_ovf;
  logic [7:0]  mq [$];
`ifdef MMIO_PRESCALE_EN
  logic [31:0] m_pre, m_pcnt;
`endif

  function automatic logic m_hit(input logic [31:0] addr);
    return addr[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    if (!m_hit(addr)) return 32'h0;
    case (addr[4:2])
      3'd0: return m_timer;
      3'd1: return m_cmp;
      3'd2: return {28'h0, m_ovf, mq.size() == 0, mq.size() == DEPTH, m_match};
      3'd3: return 32'(mq.size());
      3'd4: return {30'h0, m_ien, m_ten};
`ifdef MMIO_PRESCALE_EN
      3'd5: return m_pre;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] exp_head();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  // Applies one clock edge worth of the register-map rules to the model.
  task automatic model_update();
    logic       wr, tick, set_m, pop;
    logic [2:0] off;
    if (reset) begin
      m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_ten = 1'b0; m_ien = 1'b0;
      m_match = 1'b0; m_ovf = 1'b0; mq.delete();
`ifdef MMIO_PRESCALE_EN
      m_pre = 32'h0; m_pcnt = 32'h0;
`endif
    end else begin
      wr  = we && m_hit(a);
      off = a[4:2];
`ifdef MMIO_PRESCALE_EN
      tick = m_ten && (m_pcnt == m_pre);
`else
      tick = m_ten;
`endif
      set_m = tick && (m_timer == m_cmp);
      pop   = (mq.size() != 0) && out_ready;
`ifdef MMIO_PRESCALE_EN
      if (wr && (off == 3'd0 || off == 3'd5)) m_pcnt = 32'h0;
      else if (m_ten) m_pcnt = tick ? 32'h0 : m_pcnt + 32'd1;
      if (wr && off == 3'd5) m_pre = wd;
`endif
      if (wr && off == 3'd0) m_timer = wd;
      else if (tick) m_timer = m_timer + 32'd1;
      if (set_m) m_match = 1'b1;
      else if (wr && off == 3'd2 && wd[0]) m_match = 1'b0;
      if (wr && off == 3'd2 && wd[3]) m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (wr && off == 3'd3) begin
        if (mq.size() < DEPTH) mq.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end
      if (wr && off == 3'd1) m_cmp = wd;
      if (wr && off == 3'd4) begin m_ten = wd[0]; m_ien = wd[1]; end
    end
  endtask

  // One clock: model follows the edge, then return to the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    a = addr; wd = data; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; we = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    a = 32'h400; #1;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_timer got=%h exp=%h", rd, 32'h0); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit got=%b exp=1", hit); end
    a = 32'h404; #1;
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got=%h exp=ffffffff", rd); end
    a = 32'h408; #1;
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL reset_status got=%h exp=4", rd); end
    a = 32'h410; #1;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL reset_stream valid=%b data=%h exp 0/00", out_valid, out_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    a = 32'h500; #1;
    checks++; if (hit !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL reset_miss hit=%b rd=%h exp 0/0", hit, rd); end
  endtask

  task automatic test_timer_match();
    bus_write(32'h404, 32'd5);
    bus_write(32'h410, 32'd3);
    bus_write(32'h400, 32'd0);
    a = 32'h400;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (rd !== 32'(k)) begin errors++; $display("FAIL timer_count cyc=%0d got=%h exp=%h", k, rd, 32'(k)); end
      step();
    end
    a = 32'h408; #1;
    checks++; if (irq !== 1'b1 || rd[0] !== 1'b1) begin errors++; $display("FAIL match_set irq=%b match=%b exp 1/1", irq, rd[0]); end
    bus_write(32'h408, 32'd1);
    #1;
    checks++; if (irq !== 1'b0 || irq !== (m_match & m_ien)) begin errors++; $display("FAIL match_clear irq=%b exp=0", irq); end
    bus_write(32'h410, 32'd0);
  endtask

  task automatic test_fifo_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(32'h40C, 32'h41 + 32'(i));
    a = 32'h408; #1;
    checks++; if (rd[3:1] !== 3'b101) begin errors++; $display("FAIL ovf_status got=%b exp=101", rd[3:1]); end
    a = 32'h40C; #1;
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL ovf_count got=%h exp=4", rd); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h41 + 8'(i)) begin errors++; $display("FAIL drain%0d valid=%b data=%h exp 1/%h", i, out_valid, out_data, 8'h41 + 8'(i)); end
      step();
    end
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL drain_empty valid=%b data=%h exp 0/00", out_valid, out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h55;
    bus_write(32'h408, 32'h8);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(32'h40C, 32'h10 + 32'(i));
    out_ready = 1'b1;
    a = 32'h40C; wd = 32'h55; we = 1'b1; #1;
    checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL b2b_head got=%h exp=10", out_data); end
    step();
    we = 1'b0; out_ready = 1'b0; #1;
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL b2b_count got=%h exp=4", rd); end
    a = 32'h408; #1;
    checks++; if (rd[3] !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", rd[3]); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_b[i]) begin errors++; $display("FAIL b2b_drain%0d data=%h exp=%h", i, out_data, exp_b[i]); end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_timer_wrap();
    logic [31:0] exp_t [3];
    exp_t[0] = 32'hFFFF_FFFE; exp_t[1] = 32'hFFFF_FFFF; exp_t[2] = 32'h0;
    bus_write(32'h410, 32'd1);
    bus_write(32'h400, 32'hFFFF_FFFE);
    a = 32'h400;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rd !== exp_t[k]) begin errors++; $display("FAIL wrap%0d got=%h exp=%h", k, rd, exp_t[k]); end
      step();
    end
    bus_write(32'h400, 32'h1234);
    #1;
    checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL write_wins got=%h exp=1234", rd); end
    step(); #1;
    checks++; if (rd !== 32'h1235) begin errors++; $display("FAIL after_write got=%h exp=1235", rd); end
    bus_write(32'h410, 32'd0);
  endtask

  task automatic test_unused_offsets();
    bus_write(32'h414, 32'h7);
    bus_write(32'h418, 32'hDEAD);
    bus_write(32'h504, 32'h99);
    a = 32'h414; #1;
`ifdef MMIO_PRESCALE_EN
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL off14 got=%h exp=7", rd); end
`else
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL off14 got=%h exp=0", rd); end
`endif
    a = 32'h418; #1;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL off18 got=%h exp=0", rd); end
    a = 32'h404; #1;
    checks++; if (rd !== exp_rd(32'h404)) begin errors++; $display("FAIL miss_write got=%h exp=%h", rd, exp_rd(32'h404)); end
    a = 32'h41F; #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_top got=%b exp=1", hit); end
    a = 32'h420; #1;
    checks++; if (hit !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL hit_above hit=%b rd=%h exp 0/0", hit, rd); end
    a = 32'h3FC; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_below got=%b exp=0", hit); end
`ifdef MMIO_PRESCALE_EN
    bus_write(32'h414, 32'h0);
`endif
  endtask

`ifdef MMIO_PRESCALE_EN
  task automatic test_prescale();
    logic [31:0] seq [7];
    seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 1; seq[4] = 1; seq[5] = 1; seq[6] = 2;
    bus_write(32'h410, 32'd0);
    bus_write(32'h414, 32'd2);
    bus_write(32'h400, 32'd0);
    bus_write(32'h410, 32'd1);
    a = 32'h400;
    for (int k = 0; k < 7; k++) begin
      #1;
      checks++; if (rd !== seq[k]) begin errors++; $display("FAIL prescale%0d got=%h exp=%h", k, rd, seq[k]); end
      step();
    end
    bus_write(32'h410, 32'd0);
    bus_write(32'h414, 32'd0);
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b0;
    bus_write(32'h410, 32'd3);
    bus_write(32'h40C, 32'hA1);
    bus_write(32'h40C, 32'hA2);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    a = 32'h400; #1;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_timer got=%h exp=0", rd); end
    a = 32'h408; #1;
    checks++; if (rd !== 32'h4 || out_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL mid_state status=%h valid=%b irq=%b exp 4/0/0", rd, out_valid, irq); end
    a = 32'h410; #1;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_ctrl got=%h exp=0", rd); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      out_ready = $urandom_range(0, 1) != 0;
      we = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r < 8) a = BASE + {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      else if (r == 8) a = BASE + 32'h20;
      else a = $urandom;
      case (a[4:2])
        3'd0, 3'd1: wd = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
        3'd4:       wd = ($urandom_range(0, 3) != 0) ? 32'd3 : $urandom;
        3'd5:       wd = 32'($urandom_range(0, 3));
        default:    wd = $urandom;
      endcase
      #1;
      checks++; if (hit !== m_hit(a)) begin errors++; $display("FAIL rnd_hit c=%0d got=%b exp=%b", c, hit, m_hit(a)); end
      checks++; if (rd !== exp_rd(a)) begin errors++; $display("FAIL rnd_rd c=%0d a=%h got=%h exp=%h", c, a, rd, exp_rd(a)); end
      checks++; if (out_valid !== (mq.size() != 0) || out_data !== exp_head()) begin errors++; $display("FAIL rnd_stream c=%0d valid=%b data=%h exp %b/%h", c, out_valid, out_data, mq.size() != 0, exp_head()); end
      checks++; if (irq !== (m_match & m_ien)) begin errors++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, m_match & m_ien); end
      step();
    end
    reset = 1'b0; we = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_ten = 1'b0; m_ien = 1'b0;
    m_match = 1'b0; m_ovf = 1'b0;
`ifdef MMIO_PRESCALE_EN
    m_pre = 32'h0; m_pcnt = 32'h0;
`endif
    @(negedge clk);
    test_reset();
    test_timer_match();
    test_fifo_overflow();
    test_back_to_back();
    test_timer_wrap();
    test_unused_offsets();
`ifdef MMIO_PRESCALE_EN
    test_prescale();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
